// File: rtl/ca_descrambler_if.sv
// ----------------------------------------------------------------------------
// ca_descrambler_if
// Peripheral bus bundle shared by the CPU side (master) and the descrambler
// (slave).
//   addr     : bus address, driven by the master
//   write_en : write strobe, sampled together with addr/din
//   read_en  : read strobe; pops the plaintext queue when addr selects DATA
//   din      : write data from the master
//   dout     : read data from the slave (combinational mux on addr)
// ----------------------------------------------------------------------------
interface ca_descrambler_if;
   logic [7:0] addr;
   logic       write_en;
   logic       read_en;
   logic [7:0] din;
   logic [7:0] dout;

   modport master (
      output addr,
      output write_en,
      output read_en,
      output din,
      input  dout
   );

   modport slave (
      input  addr,
      input  write_en,
      input  read_en,
      input  din,
      output dout
   );
endinterface

// File: rtl/ca_descrambler.sv
// ----------------------------------------------------------------------------
// ca_descrambler
// Memory-mapped keystream descrambler: the receive side of the Rule-30
// cellular-automaton PRNG. The CPU writes a seed, then ciphertext bytes;
// each byte is XORed with the automaton keystream q[9:2] and the plaintext
// is queued for the CPU to read back.
//
// Register map (relative to BASE):
//   BASE+0 SEED   : write -> q = {8'h01, din}, flush queue, abort byte
//                   read  -> current keystream tap q[9:2]
//   BASE+1 DATA   : write -> ciphertext byte (dropped + overrun if busy)
//                   read  -> queue head (8'h00 when empty); read_en pops
//   BASE+2 STATUS : write -> clear overrun
//                   read  -> {busy, overrun, full, empty, 1'b0, count[2:0]}
//
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : ca_descrambler_if.slave (addr, write_en, read_en, din, dout)
//
// Parameters:
//   BASE  : base address of the three registers
//   STEPS : CA generations per data byte (1..15)
//   RULE  : Wolfram rule applied to the 16-cell ring
//
// Configuration macro:
//   CA_DESCRAMBLER_FIFO_EN : when defined the plaintext queue is a 4-deep
//   circular FIFO; otherwise it is a single holding register.
// ----------------------------------------------------------------------------
module ca_descrambler #(
   parameter logic [7:0]  BASE  = 8'd18,
   parameter int unsigned STEPS = 1,
   parameter logic [7:0]  RULE  = 8'd30
) (
   input  logic             clk,
   input  logic             rst,
   ca_descrambler_if.slave  bus
);

   localparam logic [7:0]  ADDR_SEED   = BASE;
   localparam logic [7:0]  ADDR_DATA   = BASE + 8'd1;
   localparam logic [7:0]  ADDR_STATUS = BASE + 8'd2;
   localparam logic [3:0]  STEPS_M1    = 4'(STEPS - 1);
   localparam logic [15:0] Q_RESET     = 16'h0177;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_STEP = 2'd1,
      ST_PUSH = 2'd2
   } state_t;

   // One CA generation on the 16-cell ring; left neighbour is the MSB of
   // the rule index, indices wrap mod 16.
   function automatic logic [15:0] ca_next(input logic [15:0] q, input logic [7:0] rule);
      logic [15:0] nxt;
      logic [2:0]  idx;
      nxt = 16'h0000;
      for (int i = 0; i < 16; i++) begin
         idx    = {q[(i + 15) % 16], q[i], q[(i + 1) % 16]};
         nxt[i] = rule[idx];
      end
      return nxt;
   endfunction

   state_t      state_r;
   state_t      state_nxt_s;
   logic [15:0] q_r;
   logic [7:0]  cbyte_r;
   logic [3:0]  step_cnt_r;
   logic        overrun_r;

   logic        seed_wr_s;
   logic        data_wr_s;
   logic        status_wr_s;
   logic        pop_s;
   logic        accept_s;
   logic        busy_s;
   logic        step_en_s;
   logic        push_s;
   logic        push_ok_s;
   logic        set_ovr_s;
   logic [7:0]  plain_s;

   logic        full_s;
   logic        empty_s;
   logic [2:0]  count_s;
   logic [7:0]  head_s;
   logic [7:0]  dout_s;

   // Bus decode.
   assign seed_wr_s   = bus.write_en && (bus.addr == ADDR_SEED);
   assign data_wr_s   = bus.write_en && (bus.addr == ADDR_DATA);
   assign status_wr_s = bus.write_en && (bus.addr == ADDR_STATUS);
   assign pop_s       = bus.read_en && (bus.addr == ADDR_DATA) && !empty_s;
   assign accept_s    = data_wr_s && (state_r == ST_IDLE);

   assign plain_s     = cbyte_r ^ q_r[9:2];
   // A same-cycle pop frees a slot, so a push into a full queue still lands.
   assign push_ok_s   = push_s && (!full_s || pop_s);
   assign set_ovr_s   = (data_wr_s && busy_s) || (push_s && full_s && !pop_s);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; a SEED write always returns to IDLE.
   always_comb begin
      state_nxt_s = state_r;
      if (seed_wr_s) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (data_wr_s) begin
                  state_nxt_s = ST_STEP;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_STEP: begin
               if (step_cnt_r == STEPS_M1) begin
                  state_nxt_s = ST_PUSH;
               end else begin
                  state_nxt_s = ST_STEP;
               end
            end
            ST_PUSH: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // FSM outputs; a SEED write cancels the step or push of the current cycle.
   always_comb begin
      busy_s    = 1'b0;
      step_en_s = 1'b0;
      push_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            busy_s = 1'b0;
         end
         ST_STEP: begin
            busy_s    = 1'b1;
            step_en_s = !seed_wr_s;
         end
         ST_PUSH: begin
            busy_s = 1'b1;
            push_s = !seed_wr_s;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // Automaton state, ciphertext latch, step counter and overrun flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r        <= Q_RESET;
         cbyte_r    <= 8'h00;
         step_cnt_r <= 4'd0;
         overrun_r  <= 1'b0;
      end else if (seed_wr_s) begin
         q_r        <= {8'h01, bus.din};
         step_cnt_r <= 4'd0;
         overrun_r  <= 1'b0;
      end else begin
         if (step_en_s) begin
            q_r        <= ca_next(q_r, RULE);
            step_cnt_r <= step_cnt_r + 4'd1;
         end else if (accept_s) begin
            cbyte_r    <= bus.din;
            step_cnt_r <= 4'd0;
         end else begin
            q_r        <= q_r;
         end
         // A new fault event wins over a same-cycle clear.
         if (set_ovr_s) begin
            overrun_r <= 1'b1;
         end else if (status_wr_s) begin
            overrun_r <= 1'b0;
         end else begin
            overrun_r <= overrun_r;
         end
      end
   end

`ifdef CA_DESCRAMBLER_FIFO_EN
   logic [7:0] mem_r [0:3];
   logic [1:0] rd_ptr_r;
   logic [1:0] wr_ptr_r;
   logic [2:0] count_r;

   assign full_s  = (count_r == 3'd4);
   assign empty_s = (count_r == 3'd0);
   assign count_s = count_r;
   assign head_s  = mem_r[rd_ptr_r];

   // FIFO storage; contents are only visible through count, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= plain_s;
      end
   end

   // FIFO pointers and occupancy; a SEED write flushes.
   always_ff @(posedge clk) begin
      if (rst || seed_wr_s) begin
         rd_ptr_r <= 2'd0;
         wr_ptr_r <= 2'd0;
         count_r  <= 3'd0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + 2'd1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 2'd1;
         end
         case ({push_ok_s, pop_s})
            2'b10:   count_r <= count_r + 3'd1;
            2'b01:   count_r <= count_r - 3'd1;
            default: count_r <= count_r;
         endcase
      end
   end
`else
   logic [7:0] hold_r;
   logic       valid_r;

   assign full_s  = valid_r;
   assign empty_s = !valid_r;
   assign count_s = {2'b00, valid_r};
   assign head_s  = hold_r;

   // Single-entry holding register; push wins over a same-cycle pop.
   always_ff @(posedge clk) begin
      if (rst || seed_wr_s) begin
         hold_r  <= 8'h00;
         valid_r <= 1'b0;
      end else if (push_ok_s) begin
         hold_r  <= plain_s;
         valid_r <= 1'b1;
      end else if (pop_s) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end
`endif

   // Combinational read mux selected by addr.
   always_comb begin
      dout_s = 8'h00;
      if (bus.addr == ADDR_SEED) begin
         dout_s = q_r[9:2];
      end else if (bus.addr == ADDR_DATA) begin
         dout_s = empty_s ? 8'h00 : head_s;
      end else if (bus.addr == ADDR_STATUS) begin
         dout_s = {busy_s, overrun_r, full_s, empty_s, 1'b0, count_s};
      end else begin
         dout_s = 8'h00;
      end
   end

   assign bus.dout = dout_s;

endmodule
